// File: rtl/serial_add.sv
// serial_add: bit-serial adder, one full-adder stage and a carry flop, LSB first.
// Ports: clk - rising-edge clock; rst - async active-high reset;
//        start - request an addition (accepted only when idle);
//        a, b - operands captured on the accepting edge;
//        s, c - registered sum and carry-out, held until the next completion;
//        busy - operation in progress; done - one-cycle pulse on new s/c.
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, sum_sr;
  logic [CW-1:0]    cnt;
  logic             cy, sum_bit, cy_next, last;
  assign sum_bit = op_a[0] ^ op_b[0] ^ cy;
  assign cy_next = (op_a[0] & op_b[0]) | (op_a[0] & cy) | (op_b[0] & cy);
  assign last    = cnt == CW'(WIDTH - 1);
  assign busy    = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      s      <= '0;
      c      <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_a  <= a;
          op_b  <= b;
          cy    <= 1'b0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
          cy     <= cy_next;
          cnt    <= cnt + 1'b1;
          // final bit: publish the completed sum directly, bypassing sum_sr
          if (last) begin
            s     <= {sum_bit, sum_sr[WIDTH-1:1]};
            c     <= cy_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: scoreboard bench for serial_add (WIDTH=8).
module tb_serial_add;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, s;
  logic         c, busy, done;
  int           cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct { logic [W-1:0] s; logic c; int cyc; } exp_t;
  exp_t         sb[$];

  serial_add #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                               .s(s), .c(c), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // issue one operation; E0 is the edge where start is sampled
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] sum;
    @(negedge clk);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    sum = {1'b0, x} + {1'b0, y};
    sb.push_back('{sum[W-1:0], sum[W], cyc + W});
    chk("busy_at_e0", int'(busy), 1);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
  endtask

  // monitor: pops on done, checks value and cycle; flags s/c changes without done
  logic [W:0] prev = '0;
  always @(negedge clk) begin
    if (rst) prev = {c, s};
    else begin
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", int'(s), int'(e.s));
          chk("carry", int'(c), int'(e.c));
          chk("done_cycle", cyc, e.cyc);
        end
      end else if ({c, s} != prev) chk("result_changed_without_done", 1, 0);
      prev = {c, s};
    end
  end

  initial begin
    #1;
    chk("rst_s", int'(s), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    op(8'h00, 8'h00);
    op(8'hFF, 8'h01);
    op(8'hFF, 8'hFF);
    op(8'hA5, 8'h5A);
    // a start pulse during RUN must be ignored; one done only
    op(8'h12, 8'h34);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0; a = 8'h77; b = 8'h99;
    // abort 0xFF+0x01 mid-run with an asynchronous reset
    op(8'hFF, 8'h01);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_s", int'(s), 0);
    chk("abort_c", int'(c), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    void'(sb.pop_back());
    @(negedge clk); #1 rst = 1'b0;
    op(8'h01, 8'h02);
    // start held high: back-to-back every W+2 cycles
    @(negedge clk);
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) sb.push_back('{8'h00, 1'b1, cyc + W + k * (W + 2)});
    repeat (2 * (W + 2)) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) op(W'($urandom), W'($urandom));
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) chk("pending_results_timeout", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
